// File: rtl/fifo_dualport_thr_if.sv
// Stream-buffer handshake bundle for fifo_dualport_thr: producer/consumer controls,
// head data, occupancy, threshold and sticky error flags.
interface fifo_dualport_thr_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_i;
  logic             clr_err;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, data_i, clr_err,
    input  data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  push, pop, data_i, clr_err,
    output data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_dualport_thr.sv
// First-word-fall-through FIFO on a simple dual-port RAM with registered read port;
// a bypass register hides the read latency so the head word is always on data_out.
module fifo_dualport_thr #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input logic             clk,
  input logic             rst,
  fifo_dualport_thr_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [CW-1:0] TWO_C    = CW'(2);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_addr;
  logic [CW-1:0]    count;
  logic             byp_vld_p1;
  logic [WIDTH-1:0] byp_data_p1;
  logic [WIDTH-1:0] rd_data_p1;
  logic             overflow_q;
  logic             underflow_q;

  logic empty_c;
  logic full_c;
  logic pop_ok;
  logic push_ok;
  logic byp_push;
  logic ram_wr;
  logic ram_rd;
  logic ovf_set;
  logic unf_set;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // rd_ptr marks the head's slot; the RAM always prefetches the slot after it.
  always_comb begin
    empty_c  = (count == '0);
    full_c   = (count == DEPTH_C);
    pop_ok   = bus.pop & ~empty_c;
    push_ok  = bus.push & (~full_c | pop_ok);
    byp_push = push_ok & ((count == '0) | ((count == ONE_C) & pop_ok));
    ram_wr   = push_ok & ~byp_push;
    ram_rd   = pop_ok & (count >= TWO_C);
    rd_addr  = ptr_inc(rd_ptr);
    ovf_set  = bus.push & full_c & ~pop_ok;
    unf_set  = bus.pop & empty_c;
  end

  // Stage p1: control state (pointers, occupancy, bypass flag, sticky errors)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      byp_vld_p1  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      // Bypass pushes still reserve a slot so the pointers stay in step with count.
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);

      case ({push_ok, pop_ok})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase

      if (byp_push)    byp_vld_p1 <= 1'b1;
      else if (pop_ok) byp_vld_p1 <= 1'b0;

      if (ovf_set)          overflow_q <= 1'b1;
      else if (bus.clr_err) overflow_q <= 1'b0;

      if (unf_set)          underflow_q <= 1'b1;
      else if (bus.clr_err) underflow_q <= 1'b0;
    end
  end

  // Stage p1: data path (RAM write, registered prefetch read, bypass word)
  always_ff @(posedge clk) begin
    if (ram_wr)   mem[wr_ptr] <= bus.data_i;
    if (ram_rd)   rd_data_p1  <= mem[rd_addr];
    if (byp_push) byp_data_p1 <= bus.data_i;
  end

  assign bus.data_out     = byp_vld_p1 ? byp_data_p1 : rd_data_p1;
  assign bus.count        = count;
  assign bus.empty        = empty_c;
  assign bus.full         = full_c;
  assign bus.almost_empty = (count <= AE_C);
  assign bus.almost_full  = (count >= AF_C);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_dualport_thr.sv
// Bench for fifo_dualport_thr (DEPTH=5, AE=1, AF=4): directed scenarios then random
// traffic, all checked against a queue-based model of the FIFO after every clock.
module tb_fifo_dualport_thr;
  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;

  fifo_dualport_thr_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fifo_dualport_thr #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference: contents as a queue, errors as two bits.
  logic [WIDTH-1:0] mq[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    chk("count", 32'(bus.count), 32'(n));
    chk("empty", 32'(bus.empty), 32'(n == 0));
    chk("full", 32'(bus.full), 32'(n == DEPTH));
    chk("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
    chk("almost_full", 32'(bus.almost_full), 32'(n >= AF));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_unf));
    if (n > 0) chk("data_out", 32'(bus.data_out), 32'(mq[0]));
  endtask

  task automatic step(input bit p_push, input bit p_pop, input logic [WIDTH-1:0] d,
                      input bit clr, input bit r);
    bit pop_ok, push_ok, ovf_s, unf_s;
    bus.push    = p_push;
    bus.pop     = p_pop;
    bus.data_i  = d;
    bus.clr_err = clr;
    rst         = r;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      pop_ok  = p_pop && (mq.size() > 0);
      push_ok = p_push && ((mq.size() < DEPTH) || pop_ok);
      ovf_s   = p_push && (mq.size() == DEPTH) && !pop_ok;
      unf_s   = p_pop && (mq.size() == 0);
      if (ovf_s) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
      if (unf_s) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
      if (pop_ok)  void'(mq.pop_front());
      if (push_ok) mq.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    bit rp, rq, rc, rr;
    int bias;
    bus.push = 1'b0; bus.pop = 1'b0; bus.data_i = '0; bus.clr_err = 1'b0;

    // Reset state
    step(0, 0, 8'h00, 0, 1);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);

    // Ordered push/pop with FWFT head
    step(1, 0, 8'h11, 0, 0);
    chk("fwft_head", 32'(bus.data_out), 32'h11);
    step(1, 0, 8'h22, 0, 0);
    step(1, 0, 8'h33, 0, 0);
    chk("count3", 32'(bus.count), 32'd3);
    step(0, 1, 8'h00, 0, 0);
    chk("head22", 32'(bus.data_out), 32'h22);
    step(0, 1, 8'h00, 0, 0);
    chk("head33", 32'(bus.data_out), 32'h33);
    step(0, 1, 8'h00, 0, 0);
    chk("drained_empty", 32'(bus.empty), 32'd1);

    // Fill, overflow, clear
    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(8'hC0 + i), 0, 0);
    chk("full_flag", 32'(bus.full), 32'd1);
    step(1, 0, 8'hEE, 0, 0);
    chk("overflow_set", 32'(bus.overflow), 32'd1);
    chk("head_kept", 32'(bus.data_out), 32'hC0);
    step(0, 0, 8'h00, 1, 0);
    chk("overflow_clr", 32'(bus.overflow), 32'd0);

    // Push while full with pop, then drain across the pointer wrap
    step(1, 1, 8'hAA, 0, 0);
    chk("full_pushpop_count", 32'(bus.count), 32'd5);
    chk("full_pushpop_head", 32'(bus.data_out), 32'hC1);
    for (int i = 0; i < DEPTH - 1; i++) step(0, 1, 8'h00, 0, 0);
    chk("aa_last", 32'(bus.data_out), 32'hAA);
    step(0, 1, 8'h00, 0, 0);

    // Pop on empty with a push in the same cycle
    step(1, 1, 8'h5A, 0, 0);
    chk("underflow_set", 32'(bus.underflow), 32'd1);
    chk("byp_5a", 32'(bus.data_out), 32'h5A);

    // count==1 push+pop takes the bypass
    step(1, 1, 8'h77, 1, 0);
    chk("byp_77", 32'(bus.data_out), 32'h77);
    chk("byp_77_count", 32'(bus.count), 32'd1);
    step(0, 1, 8'h00, 0, 0);

    // Threshold sweep then reset mid-fill
    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(i + 1), 0, 0);
    step(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h30 + i), 0, 0);
    step(1, 1, 8'h99, 0, 1);
    chk("midrst_count", 32'(bus.count), 32'd0);
    chk("midrst_ae", 32'(bus.almost_empty), 32'd1);

    // Randomized traffic with varying fill pressure
    for (int i = 0; i < 3000; i++) begin
      bias = ((i / 200) % 3 == 0) ? 30 : (((i / 200) % 3 == 1) ? 50 : 80);
      rp = ($urandom_range(0, 99) < bias);
      rq = ($urandom_range(0, 99) < 55);
      rc = ($urandom_range(0, 39) == 0);
      rr = ($urandom_range(0, 499) == 0);
      step(rp, rq, 8'($urandom), rc, rr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/fifo_dualport_thr.md
Name: fifo_dualport_thr

Overview:
- Parametrised first-word-fall-through FIFO built on an inferred simple dual-port block RAM with a registered read port.
- A bypass register hides the RAM read latency, so the head word always sits on data_out whenever the FIFO is non-empty.
- Adds what the earlier FIFO lacked: non-power-of-2 depth, occupancy count, programmable almost-full/almost-empty thresholds, push-while-full-with-pop, and sticky overflow/underflow error flags.
- Used as the standard stream buffer between datapath stages.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of entries (>=2, need not be a power of 2)
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
push  in  1  write request
pop  in  1  read request; consumes the current data_out word
data_i  in  WIDTH  write data
data_out  out  WIDTH  head of FIFO; valid when empty=0
empty  out  1  no entries
full  out  1  count == DEPTH
almost_empty  out  1  count <= AE_LEVEL
almost_full  out  1  count >= AF_LEVEL
count  out  $clog2(DEPTH+1)  current occupancy
overflow  out  1  sticky; push rejected while full
underflow  out  1  sticky; pop while empty
clr_err  in  1  clears overflow/underflow

Behaviour:
- Clock and reset: single clock clk; synchronous active-high reset rst.
- Reset values:
  - wr/rd pointers = 0, count = 0, empty = 1, full = 0.
  - almost_empty = 1 (with AE_LEVEL >= 0), almost_full = 0.
  - overflow = underflow = 0.
  - Bypass valid flag = 0; data_out content don't-care.
- Reset has priority over all other inputs, including an in-flight push/pop; the FIFO is emptied in one cycle.
- Accept rules, evaluated combinationally from current state:
  - pop_ok = pop & ~empty.
  - push_ok = push & (~full | pop_ok). A push is accepted when full if a pop is accepted in the same cycle.
- Pointers:
  - wr_ptr and rd_ptr count 0..DEPTH-1 and wrap explicitly from DEPTH-1 to 0. No power-of-2 assumption.
  - full and empty are derived from count, not from pointer equality.
- count next value:
  - +1 when push_ok & ~pop_ok
  - -1 when pop_ok & ~push_ok
  - unchanged otherwise.
  - Never exceeds DEPTH and never goes below 0.
- All flags (empty, full, almost_*) are decoded combinationally from the registered count. They change the cycle after the accepted operation.
- FWFT latency:
  - A word pushed into an empty FIFO appears on data_out with empty=0 on the next rising edge (1 cycle). This is the bypass path; the RAM is not written.
  - Bypass is taken when push_ok and either (count==0) or (count==1 & pop_ok).
  - Otherwise data is written to RAM at wr_ptr.
- Prefetch:
  - The RAM read address is always rd_ptr+1 (with wrap).
  - The RAM read is enabled on pop_ok when count >= 2.
  - The next head is therefore available on data_out the cycle after pop. No bubble on back-to-back pops.
- data_out mux: bypass register when the bypass flag is set, else the RAM read data.
  - Bypass flag sets on a bypass push.
  - Bypass flag clears on pop_ok without a bypass push.
- Read-during-write to the same RAM address is never required; the prefetch rules guarantee it.
- Errors:
  - overflow sets on push & full & ~pop_ok.
  - underflow sets on pop & empty.
  - Both flags hold until clr_err=1 or rst. A set in the same cycle as clr_err wins.
- Rejected operations change no state other than the error flags.

Test Plan:
- Reset, then push 0x11,0x22,0x33 on 3 consecutive cycles, then pop 3 cycles -> data_out 0x11,0x22,0x33 in order; count 1,2,3,2,1,0; empty=1 after the last pop.
- DEPTH=5: push 5 words -> full=1, count=5; 6th push -> rejected, overflow=1, data unchanged; clr_err -> overflow=0.
- Full with simultaneous push 0xAA and pop -> count stays 5, head advances, 0xAA read out 5th after further pops; wrap from pointer 4 to 0 verified.
- Empty FIFO, push 0x5A with pop asserted the same cycle -> pop ignored, underflow=1; next cycle data_out=0x5A, empty=0, count=1.
- count=1, simultaneous push 0x77 and pop -> bypass taken; next cycle data_out=0x77, count=1; RAM not written.
- AE_LEVEL=1, AF_LEVEL=4, DEPTH=5: fill 0..5 -> almost_empty=1 at count 0–1, almost_full=1 at count 4–5; rst asserted at count 3 -> all outputs at reset values next cycle.
